// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_pkg
//  Description : Shared types and default widths for the video/CPU memory
//                arbiter: read-owner encoding and default address/data widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_addr_w = 12;   // default RAM address width
    localparam int c_data_w = 8;    // default RAM data width

    // Who the read data coming back from the RAM this cycle belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_VID  = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_if
//  Description : Bus bundle between the CPU port, the video port, the RAM and
//                the arbiter.
//                  CPU  : cpu_req/cpu_rw/cpu_addr/cpu_wdata -> cpu_gnt,
//                         cpu_rdata, cpu_rvalid
//                  VID  : vid_req/vid_addr -> vid_gnt, vid_rdata, vid_rvalid
//                  RAM  : ram_cs/ram_rw/ram_addr/ram_wdata <- ram_rdata
//                modport slave  : arbiter side
//                modport master : requester/RAM side
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_arb_if
    import mem_arb_pkg::*;
#(
    parameter int A = c_addr_w,
    parameter int D = c_data_w
) ();

    // CPU port
    logic         cpu_req;
    logic         cpu_rw;      // 1 = read, 0 = write
    logic [A-1:0] cpu_addr;
    logic [D-1:0] cpu_wdata;
    logic         cpu_gnt;
    logic [D-1:0] cpu_rdata;
    logic         cpu_rvalid;

    // Video port (read-only)
    logic         vid_req;
    logic [A-1:0] vid_addr;
    logic         vid_gnt;
    logic [D-1:0] vid_rdata;
    logic         vid_rvalid;

    // RAM port (read data returns one clk after ram_cs)
    logic         ram_cs;
    logic         ram_rw;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_wdata;
    logic [D-1:0] ram_rdata;

    modport slave (
        input  cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rdata, cpu_rvalid,
        input  vid_req, vid_addr,
        output vid_gnt, vid_rdata, vid_rvalid,
        output ram_cs, ram_rw, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output cpu_req, cpu_rw, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rdata, cpu_rvalid,
        output vid_req, vid_addr,
        input  vid_gnt, vid_rdata, vid_rvalid,
        input  ram_cs, ram_rw, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_starve_counter.sv
`default_nettype none
// ============================================================================
//  Module      : starve_counter
//  Description : Saturating count of consecutive denied CPU cycles. Only
//                instantiated when MEM_ARB_STARVE_GUARD_EN is defined.
//                  clk, reset : clock, synchronous active-high reset
//                  inc        : CPU requesting and not granted this cycle
//                  clr        : CPU granted or not requesting (wins over inc)
//                  sat        : count has reached MAX_WAIT
//  Revision    : 1.0 - initial release
// ============================================================================
module starve_counter #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int c_cnt_w = $clog2(MAX_WAIT + 1);

    logic [c_cnt_w-1:0] r_cnt;
    logic               w_sat;

    assign w_sat = (r_cnt == c_cnt_w'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !w_sat) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign sat = w_sat;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Single-port RAM arbiter between a CPU and a video fetcher.
//                Video has strict priority; one access per clock; read data
//                is routed back to the requester that issued the read one
//                clock after the grant.
//                  clk, reset : clock, synchronous active-high reset
//                  bus        : mem_arb_if.slave (CPU, video and RAM signals)
//                Optional feature macro MEM_ARB_STARVE_GUARD_EN: after
//                MAX_WAIT consecutive denied CPU cycles the CPU is granted
//                over video for one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int A        = c_addr_w,
    parameter int D        = c_data_w,
    parameter int MAX_WAIT = 4
) (
    input  logic      clk,
    input  logic      reset,
    mem_arb_if.slave  bus
);

    logic         w_force_cpu;
    logic         w_cpu_gnt;
    logic         w_vid_gnt;
    logic         w_ram_cs;
    logic         w_ram_rw;
    logic [A-1:0] w_ram_addr;
    logic [D-1:0] w_ram_wdata;
    logic         w_cpu_rvalid;
    logic         w_vid_rvalid;

    owner_t       r_owner;
    logic [D-1:0] r_cpu_rdata;
    logic [D-1:0] r_vid_rdata;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic w_starve_sat;

    starve_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (bus.cpu_req && !w_cpu_gnt),
        .clr   (w_cpu_gnt || !bus.cpu_req),
        .sat   (w_starve_sat)
    );

    assign w_force_cpu = w_starve_sat && bus.cpu_req;
`else
    logic w_unused_max_wait;

    assign w_unused_max_wait = (MAX_WAIT != 0);
    assign w_force_cpu       = 1'b0;
`endif

    // Grant and RAM command decode; everything idles while reset is high
    always_comb begin
        w_cpu_gnt   = 1'b0;
        w_vid_gnt   = 1'b0;
        w_ram_cs    = 1'b0;
        w_ram_rw    = 1'b1;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (!reset) begin
            if (bus.vid_req && !w_force_cpu) begin
                w_vid_gnt  = 1'b1;
                w_ram_cs   = 1'b1;
                w_ram_addr = bus.vid_addr;
            end else if (bus.cpu_req) begin
                w_cpu_gnt   = 1'b1;
                w_ram_cs    = 1'b1;
                w_ram_rw    = bus.cpu_rw;
                w_ram_addr  = bus.cpu_addr;
                w_ram_wdata = bus.cpu_wdata;
            end
        end
    end

    // Tag the read in flight so the returning RAM data goes to its issuer
    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= OWN_NONE;
        end else if (w_vid_gnt) begin
            r_owner <= OWN_VID;
        end else if (w_cpu_gnt && bus.cpu_rw) begin
            r_owner <= OWN_CPU;
        end else begin
            r_owner <= OWN_NONE;
        end
    end

    // Reset gates the return path so an in-flight read is dropped at once
    assign w_cpu_rvalid = !reset && (r_owner == OWN_CPU);
    assign w_vid_rvalid = !reset && (r_owner == OWN_VID);

    // Last delivered value, shown while rvalid is low
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cpu_rdata <= '0;
            r_vid_rdata <= '0;
        end else begin
            if (w_cpu_rvalid) r_cpu_rdata <= bus.ram_rdata;
            if (w_vid_rvalid) r_vid_rdata <= bus.ram_rdata;
        end
    end

    assign bus.cpu_gnt    = w_cpu_gnt;
    assign bus.vid_gnt    = w_vid_gnt;
    assign bus.ram_cs     = w_ram_cs;
    assign bus.ram_rw     = w_ram_rw;
    assign bus.ram_addr   = w_ram_addr;
    assign bus.ram_wdata  = w_ram_wdata;
    assign bus.cpu_rvalid = w_cpu_rvalid;
    assign bus.vid_rvalid = w_vid_rvalid;
    assign bus.cpu_rdata  = reset ? '0 : (w_cpu_rvalid ? bus.ram_rdata : r_cpu_rdata);
    assign bus.vid_rdata  = reset ? '0 : (w_vid_rvalid ? bus.ram_rdata : r_vid_rdata);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Directed self-checking bench for mem_arbiter with a
//                one-cycle-latency RAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_a   = 12;
    localparam int c_d   = 8;
    localparam int c_max = 4;

    logic clk;
    logic reset;

    int n_checks;
    int n_errors;

    mem_arb_if #(.A(c_a), .D(c_d)) bus ();

    mem_arbiter #(
        .A        (c_a),
        .D        (c_d),
        .MAX_WAIT (c_max)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous, read data one clk after ram_cs
    logic [c_d-1:0] mem [0:(1<<c_a)-1];

    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_rw) bus.ram_rdata <= mem[bus.ram_addr];
            else            mem[bus.ram_addr] <= bus.ram_wdata;
        end
    end

    function automatic logic [7:0] pat(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h3C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle; inputs are changed 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle before sampling
    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        bus.cpu_req   = 1'b0;
        bus.cpu_rw    = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
    endtask

    initial begin
        logic exp_cpu;

        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < (1 << c_a); i++) mem[i] = pat(12'(i));
        mem[12'h010] = 8'hA5;
        bus.ram_rdata = '0;
        idle_inputs();
        reset = 1'b1;

        // ---------------- reset state, even with requests pending
        tick(); tick();
        bus.cpu_req = 1'b1;
        bus.vid_req = 1'b1;
        settle();
        chk("rst_cpu_gnt",    bus.cpu_gnt,    0);
        chk("rst_vid_gnt",    bus.vid_gnt,    0);
        chk("rst_ram_cs",     bus.ram_cs,     0);
        chk("rst_ram_rw",     bus.ram_rw,     1);
        chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("rst_vid_rvalid", bus.vid_rvalid, 0);
        chk("rst_cpu_rdata",  bus.cpu_rdata,  0);
        chk("rst_vid_rdata",  bus.vid_rdata,  0);
        tick();
        idle_inputs();
        reset = 1'b0;
        settle();
        chk("idle_ram_cs", bus.ram_cs, 0);
        chk("idle_ram_rw", bus.ram_rw, 1);

        // ---------------- CPU read alone
        tick();
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 12'h010;
        settle();
        chk("rd_cpu_gnt",  bus.cpu_gnt,  1);
        chk("rd_vid_gnt",  bus.vid_gnt,  0);
        chk("rd_ram_cs",   bus.ram_cs,   1);
        chk("rd_ram_rw",   bus.ram_rw,   1);
        chk("rd_ram_addr", bus.ram_addr, 12'h010);
        tick();
        idle_inputs();
        settle();
        chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("rd_cpu_rdata",  bus.cpu_rdata,  8'hA5);
        chk("rd_vid_rvalid", bus.vid_rvalid, 0);
        tick();
        settle();
        chk("rd_rvalid_once", bus.cpu_rvalid, 0);
        chk("rd_rdata_hold",  bus.cpu_rdata,  8'hA5);

        // ---------------- conflict: video wins, CPU served next cycle
        bus.vid_req = 1'b1; bus.vid_addr = 12'h020;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 12'h011;
        settle();
        chk("cf_vid_gnt",  bus.vid_gnt,  1);
        chk("cf_cpu_gnt",  bus.cpu_gnt,  0);
        chk("cf_ram_addr", bus.ram_addr, 12'h020);
        tick();
        bus.vid_req = 1'b0;
        settle();
        chk("cf_cpu_gnt2",   bus.cpu_gnt,    1);
        chk("cf_ram_addr2",  bus.ram_addr,   12'h011);
        chk("cf_vid_rvalid", bus.vid_rvalid, 1);
        chk("cf_vid_rdata",  bus.vid_rdata,  pat(12'h020));
        chk("cf_cpu_rv0",    bus.cpu_rvalid, 0);
        tick();
        idle_inputs();
        settle();
        chk("cf_cpu_rvalid", bus.cpu_rvalid, 1);
        chk("cf_cpu_rdata",  bus.cpu_rdata,  pat(12'h011));
        chk("cf_vid_rv0",    bus.vid_rvalid, 0);
        chk("cf_vid_hold",   bus.vid_rdata,  pat(12'h020));
        tick();

        // ---------------- CPU write, then read back
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = 12'h03F; bus.cpu_wdata = 8'h5A;
        settle();
        chk("wr_cpu_gnt",   bus.cpu_gnt,   1);
        chk("wr_ram_cs",    bus.ram_cs,    1);
        chk("wr_ram_rw",    bus.ram_rw,    0);
        chk("wr_ram_wdata", bus.ram_wdata, 8'h5A);
        tick();
        idle_inputs();
        settle();
        chk("wr_no_cpu_rv", bus.cpu_rvalid, 0);
        chk("wr_no_vid_rv", bus.vid_rvalid, 0);
        tick();
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 12'h03F;
        settle();
        chk("wr_rb_gnt", bus.cpu_gnt, 1);
        tick();
        idle_inputs();
        settle();
        chk("wr_rb_rvalid", bus.cpu_rvalid, 1);
        chk("wr_rb_rdata",  bus.cpu_rdata,  8'h5A);
        tick();

        // ---------------- starvation: both request continuously
        bus.vid_req = 1'b1; bus.vid_addr = 12'h040;
        bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 12'h041;
        for (int c = 0; c < 20; c++) begin
            settle();
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_cpu = ((c % (c_max + 1)) == c_max);
`else
            exp_cpu = 1'b0;
`endif
            chk($sformatf("sv_cpu_gnt_c%0d", c), bus.cpu_gnt, 32'(exp_cpu));
            chk($sformatf("sv_vid_gnt_c%0d", c), bus.vid_gnt, 32'(!exp_cpu));
            tick();
        end
        idle_inputs();
        tick(); tick();

        // ---------------- reset while a video read is in flight
        bus.vid_req = 1'b1; bus.vid_addr = 12'h030;
        settle();
        chk("mr_vid_gnt", bus.vid_gnt, 1);
        tick();
        idle_inputs();
        reset = 1'b1;
        settle();
        chk("mr_vid_rvalid", bus.vid_rvalid, 0);
        chk("mr_cpu_rvalid", bus.cpu_rvalid, 0);
        chk("mr_vid_rdata",  bus.vid_rdata,  0);
        chk("mr_cpu_rdata",  bus.cpu_rdata,  0);
        chk("mr_ram_cs",     bus.ram_cs,     0);
        chk("mr_ram_rw",     bus.ram_rw,     1);
        tick();
        reset = 1'b0;
        settle();
        chk("mr_post_vid_rv", bus.vid_rvalid, 0);
        chk("mr_post_vid_rd", bus.vid_rdata,  0);
        tick();

        // ---------------- alternating back-to-back reads
        for (int k = 0; k <= 8; k++) begin
            idle_inputs();
            if (k < 8) begin
                if (k % 2 == 0) begin
                    bus.vid_req = 1'b1; bus.vid_addr = 12'(12'h100 + k);
                end else begin
                    bus.cpu_req = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = 12'(12'h200 + k);
                end
            end
            settle();
            if (k < 8) begin
                chk($sformatf("alt_vid_gnt_%0d", k), bus.vid_gnt, 32'(k % 2 == 0));
                chk($sformatf("alt_cpu_gnt_%0d", k), bus.cpu_gnt, 32'(k % 2 == 1));
            end
            if (k > 0) begin
                if ((k - 1) % 2 == 0) begin
                    chk($sformatf("alt_vid_rv_%0d", k), bus.vid_rvalid, 1);
                    chk($sformatf("alt_cpu_rv_%0d", k), bus.cpu_rvalid, 0);
                    chk($sformatf("alt_vid_rd_%0d", k), bus.vid_rdata, pat(12'(12'h100 + k - 1)));
                end else begin
                    chk($sformatf("alt_cpu_rv_%0d", k), bus.cpu_rvalid, 1);
                    chk($sformatf("alt_vid_rv_%0d", k), bus.vid_rvalid, 0);
                    chk($sformatf("alt_cpu_rd_%0d", k), bus.cpu_rdata, pat(12'(12'h200 + k - 1)));
                end
            end
            tick();
        end
        idle_inputs();
        settle();
        chk("alt_drain_cpu_rv", bus.cpu_rvalid, 0);
        chk("alt_drain_vid_rv", bus.vid_rvalid, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
